pipeline_hazard_ctrl: RTL and testbench

Hazard, forwarding and exception-sequencing controller for the 5-stage MIPS pipeline. It drives the EN/CLR/flush inputs of every stage register, including EN/CLR of the memory-to-writeback register. It also drives the forwarding-mux selects and the PC-source select. A small FSM sequences multi-cycle multiply/divide stalls and the exception flush/redirect handshake with the coprocessor.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_forward_unit.sv | 64 ++++++
 rtl/pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters).
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        MD_BUSY      = 2'd1,
        EXC_FLUSH    = 2'd2,
        EXC_REDIRECT = 2'd3
    } state_t;

    // Forwarding-mux select encodings (Execute operands)
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // PC-source select encodings
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_VEC = 2'b01;
    localparam logic [1:0] PC_EPC = 2'b10;

endpackage

// File: rtl/hazard_forward_unit.sv
// Purely combinational forwarding-select and hazard-detect compare logic.
// Register 0 is hard-wired, so a zero destination never produces a match.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] rs_d,
    input  logic [WIDTH-1:0] rt_d,
    input  logic [WIDTH-1:0] rs_e,
    input  logic [WIDTH-1:0] rt_e,
    input  logic [WIDTH-1:0] write_reg_e,
    input  logic [WIDTH-1:0] write_reg_m,
    input  logic [WIDTH-1:0] write_reg_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    input  logic             branch_d,
    input  logic             jr_d,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic             lwstall,
    output logic             brstall
);

    function automatic logic hit(input logic [WIDTH-1:0] dst, input logic [WIDTH-1:0] src);
        return (dst != {WIDTH{1'b0}}) && (dst == src);
    endfunction

    // Execute-stage operand forwarding: the younger M result beats the W result
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (reg_write_m && hit(write_reg_m, rs_e)) begin
            forward_a_e = FWD_M;
        end else if (reg_write_w && hit(write_reg_w, rs_e)) begin
            forward_a_e = FWD_W;
        end else begin
            forward_a_e = FWD_RF;
        end
        if (reg_write_m && hit(write_reg_m, rt_e)) begin
            forward_b_e = FWD_M;
        end else if (reg_write_w && hit(write_reg_w, rt_e)) begin
            forward_b_e = FWD_W;
        end else begin
            forward_b_e = FWD_RF;
        end
    end

    // Decode-stage branch-compare forwarding and stall detection
    always_comb begin
        forward_a_d = reg_write_m && hit(write_reg_m, rs_d);
        forward_b_d = reg_write_m && hit(write_reg_m, rt_d);
        lwstall     = mem_to_reg_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
        brstall     = (branch_d || jr_d) &&
                      ((reg_write_e  && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
                       (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and exception-sequencing controller for the 5-stage pipeline.
// Control outputs are combinational from the FSM state and current stage inputs,
// and are forced to their idle values while rst is high.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WIDTH_5   = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH_5-1:0] Rs_D,
    input  logic [WIDTH_5-1:0] Rt_D,
    input  logic [WIDTH_5-1:0] Rs_E,
    input  logic [WIDTH_5-1:0] Rt_E,
    input  logic [WIDTH_5-1:0] WriteReg_E,
    input  logic [WIDTH_5-1:0] WriteReg_M,
    input  logic [WIDTH_5-1:0] WriteReg_W,
    input  logic               RegWrite_E,
    input  logic               RegWrite_M,
    input  logic               RegWrite_W,
    input  logic               MemtoReg_E,
    input  logic               MemtoReg_M,
    input  logic               Branch_D,
    input  logic               Jr_D,
    input  logic               md_start_E,
    input  logic               exception_M,
    input  logic               eret_M,
    output logic               Stall_F,
    output logic               Stall_D,
    output logic               Stall_E,
    output logic               Flush_D,
    output logic               Flush_E,
    output logic               Flush_M,
    output logic               EN_MW,
    output logic               CLR_MW,
    output logic [1:0]         ForwardA_E,
    output logic [1:0]         ForwardB_E,
    output logic               ForwardA_D,
    output logic               ForwardB_D,
    output logic [1:0]         pc_sel,
    output logic               epc_we,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        stall_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic               md_done
);

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] md_cnt;
    logic [7:0] md_cnt_next;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;
    logic       lwstall;
    logic       brstall;
    logic       exc_take;

    hazard_forward_unit #(.WIDTH(WIDTH_5)) u_fwd (
        .rs_d         (Rs_D),
        .rt_d         (Rt_D),
        .rs_e         (Rs_E),
        .rt_e         (Rt_E),
        .write_reg_e  (WriteReg_E),
        .write_reg_m  (WriteReg_M),
        .write_reg_w  (WriteReg_W),
        .reg_write_e  (RegWrite_E),
        .reg_write_m  (RegWrite_M),
        .reg_write_w  (RegWrite_W),
        .mem_to_reg_e (MemtoReg_E),
        .mem_to_reg_m (MemtoReg_M),
        .branch_d     (Branch_D),
        .jr_d         (Jr_D),
        .forward_a_e  (fwd_a_e),
        .forward_b_e  (fwd_b_e),
        .forward_a_d  (fwd_a_d),
        .forward_b_d  (fwd_b_d),
        .lwstall      (lwstall),
        .brstall      (brstall)
    );

    // An exception is only accepted while the pipeline is running or multi-cycle busy
    assign exc_take = exception_M && ((state == RUN) || (state == MD_BUSY));

    // State and occupancy-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    // Next-state: exception aborts everything; a load-use stall defers a divider issue
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        case (state)
            RUN: begin
                if (exception_M) begin
                    state_next  = EXC_FLUSH;
                    md_cnt_next = 8'd0;
                end else if (md_start_E && !lwstall) begin
                    state_next  = MD_BUSY;
                    md_cnt_next = MD_LOAD;
                end else begin
                    state_next  = RUN;
                end
            end
            MD_BUSY: begin
                if (exception_M) begin
                    state_next  = EXC_FLUSH;
                    md_cnt_next = 8'd0;
                end else if (md_cnt <= 8'd1) begin
                    state_next  = RUN;
                    md_cnt_next = 8'd0;
                end else begin
                    md_cnt_next = md_cnt - 8'd1;
                end
            end
            EXC_FLUSH:    state_next = EXC_REDIRECT;
            EXC_REDIRECT: state_next = RUN;
            default: begin
                state_next  = RUN;
                md_cnt_next = 8'd0;
            end
        endcase
    end

    // Output decode: stage enables/clears, forwarding selects and PC source
    always_comb begin
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        Flush_M    = 1'b0;
        EN_MW      = 1'b1;
        CLR_MW     = 1'b0;
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        ForwardA_D = 1'b0;
        ForwardB_D = 1'b0;
        pc_sel     = PC_SEQ;
        epc_we     = 1'b0;
        md_done    = 1'b0;
        if (!rst) begin
            ForwardA_E = fwd_a_e;
            ForwardB_E = fwd_b_e;
            ForwardA_D = fwd_a_d;
            ForwardB_D = fwd_b_d;
            if (exc_take) begin
                // Kill the faulting instruction before W and capture EPC/Cause
                CLR_MW  = 1'b1;
                Flush_D = 1'b1;
                Flush_E = 1'b1;
                Flush_M = 1'b1;
                epc_we  = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (eret_M) begin
                            pc_sel  = PC_EPC;
                            Flush_D = 1'b1;
                            Flush_E = 1'b1;
                            Flush_M = 1'b1;
                        end else begin
                            Stall_F = lwstall | brstall;
                            Stall_D = lwstall | brstall;
                            Flush_E = lwstall | brstall;
                        end
                    end
                    MD_BUSY: begin
                        // Hold F/D/E, bubble into M so older work drains through W
                        Stall_F = 1'b1;
                        Stall_D = 1'b1;
                        Stall_E = 1'b1;
                        Flush_M = 1'b1;
                        md_done = (md_cnt <= 8'd1);
                    end
                    EXC_FLUSH: begin
                        Flush_D = 1'b1;
                        Flush_E = 1'b1;
                        Flush_M = 1'b1;
                        pc_sel  = PC_VEC;
                    end
                    EXC_REDIRECT: Flush_D = 1'b1;
                    default:      Flush_D = 1'b0;
                endcase
            end
        end else begin
            EN_MW = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Wrapping performance counters: front-end stall cycles and exception entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (Stall_F) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (exc_take) begin
                flush_cnt <= flush_cnt + 16'd1;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MD_CYCLES = 4).
// Optional feature macro: HAZARD_PERF_CNT_EN (counter ports connected when defined).
module tb_pipeline_hazard_ctrl;

    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic       Branch_D, Jr_D, md_start_E, exception_M, eret_M;
    logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, EN_MW, CLR_MW;
    logic [1:0] ForwardA_E, ForwardB_E, pc_sel;
    logic       ForwardA_D, ForwardB_D, epc_we, md_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WIDTH_5(5), .MD_CYCLES(MDC)) dut (
        .clk(clk), .rst(rst),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .md_start_E(md_start_E),
        .exception_M(exception_M), .eret_M(eret_M),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
        .EN_MW(EN_MW), .CLR_MW(CLR_MW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
        .pc_sel(pc_sel), .epc_we(epc_we),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .md_done(md_done)
    );

    // Observed outputs packed as {sF,sD,sE,fD,fE,fM,EN_MW,CLR_MW,FA_E,FB_E,FA_D,FB_D,pc_sel,epc_we,md_done}
    logic [17:0] obs;
    assign obs = {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, EN_MW, CLR_MW,
                  ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D, pc_sel, epc_we, md_done};

    localparam logic [17:0] IDLE_VEC     = 18'h00800;
    localparam logic [17:0] REDIRECT_VEC = 18'h04800;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: cycles of multiply/divide occupancy left, cycles of exception sequence left
    int md_left  = 0;
    int exc_left = 0;

    function automatic bit hit(input logic [4:0] d, input logic [4:0] s);
        return (d != 5'd0) && (d == s);
    endfunction

    function automatic bit lw_now();
        return MemtoReg_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D));
    endfunction

    function automatic logic [17:0] model_out();
        logic sf, sd, se, fd, fe, fm, clr, epc, done, fad, fbd;
        logic [1:0] fa, fb, pc;
        bit br;
        {sf, sd, se, fd, fe, fm, clr, epc, done, fad, fbd} = 11'd0;
        fa = 2'b00; fb = 2'b00; pc = 2'b00;
        if (rst) return IDLE_VEC;
        if (RegWrite_M && hit(WriteReg_M, Rs_E)) fa = 2'b10;
        else if (RegWrite_W && hit(WriteReg_W, Rs_E)) fa = 2'b01;
        if (RegWrite_M && hit(WriteReg_M, Rt_E)) fb = 2'b10;
        else if (RegWrite_W && hit(WriteReg_W, Rt_E)) fb = 2'b01;
        fad = RegWrite_M && hit(WriteReg_M, Rs_D);
        fbd = RegWrite_M && hit(WriteReg_M, Rt_D);
        br = (Branch_D || Jr_D) &&
             ((RegWrite_E && (hit(WriteReg_E, Rs_D) || hit(WriteReg_E, Rt_D))) ||
              (MemtoReg_M && (hit(WriteReg_M, Rs_D) || hit(WriteReg_M, Rt_D))));
        if (exc_left == 2) begin
            fd = 1'b1; fe = 1'b1; fm = 1'b1; pc = 2'b01;
        end else if (exc_left == 1) begin
            fd = 1'b1;
        end else if (exception_M) begin
            clr = 1'b1; fd = 1'b1; fe = 1'b1; fm = 1'b1; epc = 1'b1;
        end else if (md_left > 0) begin
            sf = 1'b1; sd = 1'b1; se = 1'b1; fm = 1'b1; done = (md_left == 1);
        end else if (eret_M) begin
            fd = 1'b1; fe = 1'b1; fm = 1'b1; pc = 2'b10;
        end else if (lw_now() || br) begin
            sf = 1'b1; sd = 1'b1; fe = 1'b1;
        end
        return {sf, sd, se, fd, fe, fm, 1'b1, clr, fa, fb, fad, fbd, pc, epc, done};
    endfunction

    // Advance the clock one cycle and the reference model with it
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            md_left = 0; exc_left = 0;
        end else if (exc_left > 0) begin
            exc_left = exc_left - 1;
        end else if (exception_M) begin
            exc_left = 2; md_left = 0;
        end else if (md_left > 0) begin
            md_left = md_left - 1;
        end else if (md_start_E && !lw_now()) begin
            md_left = MDC - 1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W} = 35'd0;
        {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M} = 5'd0;
        {Branch_D, Jr_D, md_start_E, exception_M, eret_M} = 5'd0;
    endtask

    task automatic rand_inputs(input int ctl_odds);
        Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3));
        Rs_E = 5'($urandom_range(0, 3)); Rt_E = 5'($urandom_range(0, 3));
        WriteReg_E = 5'($urandom_range(0, 3)); WriteReg_M = 5'($urandom_range(0, 3));
        WriteReg_W = 5'($urandom_range(0, 3));
        RegWrite_E = 1'($urandom_range(0, 1)); RegWrite_M = 1'($urandom_range(0, 1));
        RegWrite_W = 1'($urandom_range(0, 1)); MemtoReg_E = 1'($urandom_range(0, 1));
        MemtoReg_M = 1'($urandom_range(0, 1)); Branch_D = 1'($urandom_range(0, 1));
        Jr_D = 1'($urandom_range(0, 3) == 0);
        md_start_E  = 1'($urandom_range(0, ctl_odds) == 0);
        exception_M = 1'($urandom_range(0, ctl_odds + 6) == 0);
        eret_M      = 1'($urandom_range(0, ctl_odds + 6) == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1);
            #2;
            vectors++;
            if (obs !== IDLE_VEC) begin
                miscompares++;
                $display("FAIL reset[%0d]: outputs got %h expected %h", i, obs, IDLE_VEC);
            end
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        #2;
        vectors++;
        if (obs !== IDLE_VEC) begin
            miscompares++;
            $display("FAIL reset_release: outputs got %h expected %h", obs, IDLE_VEC);
        end
        tick();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        RegWrite_M = 1'b1; WriteReg_M = 5'd8; Rs_E = 5'd8; RegWrite_W = 1'b1; WriteReg_W = 5'd8;
        #2;
        vectors++;
        if (ForwardA_E !== 2'b10) begin
            miscompares++;
            $display("FAIL fwd_m_priority: ForwardA_E got %b expected 10", ForwardA_E);
        end
        tick();
        WriteReg_M = 5'd0;
        #2;
        vectors++;
        if (ForwardA_E !== 2'b01) begin
            miscompares++;
            $display("FAIL fwd_zero_m: ForwardA_E got %b expected 01", ForwardA_E);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            rand_inputs(1000);
            exception_M = 1'b0; eret_M = 1'b0; md_start_E = 1'b0;
            #2;
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL fwd_rand[%0d]: outputs got %h expected %h", i, obs, model_out());
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        MemtoReg_E = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd5; Rt_D = 5'd5;
        #2;
        vectors++;
        if ({Stall_F, Stall_D, Stall_E, Flush_E} !== 4'b1101) begin
            miscompares++;
            $display("FAIL loaduse_hit: {sF,sD,sE,fE} got %b expected 1101", {Stall_F, Stall_D, Stall_E, Flush_E});
        end
        tick();
        idle_inputs();
        #2;
        vectors++;
        if (obs !== IDLE_VEC) begin
            miscompares++;
            $display("FAIL loaduse_release: outputs got %h expected %h", obs, IDLE_VEC);
        end
        tick();
    endtask

    task automatic test_muldiv();
        idle_inputs();
        md_start_E = 1'b1;
        for (int i = 0; i < MDC + 2; i++) begin
            #2;
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL muldiv[%0d]: outputs got %h expected %h", i, obs, model_out());
            end
            tick();
            md_start_E = 1'b0;
        end
    endtask

    task automatic test_exc_mid_md();
        idle_inputs();
        md_start_E = 1'b1;
        tick();
        md_start_E = 1'b0;
        tick();
        exception_M = 1'b1;
        #2;
        vectors++;
        if ({CLR_MW, epc_we, Stall_F, Stall_E} !== 4'b1100) begin
            miscompares++;
            $display("FAIL exc_md_take: {clr,epc,sF,sE} got %b expected 1100", {CLR_MW, epc_we, Stall_F, Stall_E});
        end
        tick();
        exception_M = 1'b1;
        #2;
        vectors++;
        if (pc_sel !== 2'b01 || obs !== model_out()) begin
            miscompares++;
            $display("FAIL exc_md_vector: outputs got %h expected %h", obs, model_out());
        end
        tick();
        exception_M = 1'b0;
        #2;
        vectors++;
        if (obs !== REDIRECT_VEC) begin
            miscompares++;
            $display("FAIL exc_md_redirect: outputs got %h expected %h", obs, REDIRECT_VEC);
        end
        tick();
        #2;
        vectors++;
        if (obs !== IDLE_VEC) begin
            miscompares++;
            $display("FAIL exc_md_run: outputs got %h expected %h", obs, IDLE_VEC);
        end
        tick();
    endtask

    task automatic test_collisions();
        idle_inputs();
        exception_M = 1'b1; eret_M = 1'b1;
        #2;
        vectors++;
        if (pc_sel !== 2'b00 || CLR_MW !== 1'b1) begin
            miscompares++;
            $display("FAIL exc_eret_same: pc_sel/clr got %b/%b expected 00/1", pc_sel, CLR_MW);
        end
        tick();
        exception_M = 1'b0; eret_M = 1'b0;
        #2;
        vectors++;
        if (pc_sel !== 2'b01) begin
            miscompares++;
            $display("FAIL exc_eret_next: pc_sel got %b expected 01", pc_sel);
        end
        tick();
        tick();
        MemtoReg_E = 1'b1; WriteReg_E = 5'd3; Rs_D = 5'd3; md_start_E = 1'b1;
        #2;
        vectors++;
        if (obs !== model_out()) begin
            miscompares++;
            $display("FAIL lw_md_same: outputs got %h expected %h", obs, model_out());
        end
        tick();
        idle_inputs();
        #2;
        vectors++;
        if (Stall_E !== 1'b0 || obs !== IDLE_VEC) begin
            miscompares++;
            $display("FAIL lw_md_next: outputs got %h expected %h", obs, IDLE_VEC);
        end
        tick();
    endtask

    task automatic test_reset_mid_exc();
        idle_inputs();
        exception_M = 1'b1;
        tick();
        exception_M = 1'b0;
        RegWrite_M = 1'b1; WriteReg_M = 5'd2; Rs_E = 5'd2;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== IDLE_VEC) begin
            miscompares++;
            $display("FAIL rst_mid_exc: outputs got %h expected %h", obs, IDLE_VEC);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        #2;
        vectors++;
        if (obs !== IDLE_VEC) begin
            miscompares++;
            $display("FAIL rst_mid_exc_release: outputs got %h expected %h", obs, IDLE_VEC);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(9);
            #2;
            vectors++;
            if (obs !== model_out()) begin
                miscompares++;
                $display("FAIL random[%0d]: outputs got %h expected %h", i, obs, model_out());
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_exc_mid_md();
        test_collisions();
        test_reset_mid_exc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
